// File: rtl/button_bank.sv
// button_bank: N-channel button front end. Two-flop synchroniser, per-channel
// counter debounce, sticky press/release flags with read-to-clear, per-channel
// IRQ enable and a registered level interrupt. The CPU reads and writes it over
// the GPIO bus.
module button_bank #(
  parameter int unsigned NUM_BTN         = 8,
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_BTN-1:0] btn_in,
  input  logic               ren,
  input  logic               wen,
  input  logic [31:0]        address,
  input  logic [31:0]        wdata,
  output logic [31:0]        data_out,
  output logic               rvalid,
  output logic               irq
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  typedef enum logic [1:0] {
    REG_STATE   = 2'b00,
    REG_PRESS   = 2'b01,
    REG_RELEASE = 2'b10,
    REG_IRQ_EN  = 2'b11
  } reg_sel_e;

  logic [NUM_BTN-1:0] sync_s1;
  logic [NUM_BTN-1:0] sync_s2;
  logic [NUM_BTN-1:0] stable;
  logic [NUM_BTN-1:0] stable_nxt;
  logic [CNT_W-1:0]   cnt     [NUM_BTN];
  logic [CNT_W-1:0]   cnt_nxt [NUM_BTN];
  logic [NUM_BTN-1:0] press_q;
  logic [NUM_BTN-1:0] release_q;
  logic [NUM_BTN-1:0] irq_en_q;
  logic [NUM_BTN-1:0] press_set;
  logic [NUM_BTN-1:0] release_set;
  logic [NUM_BTN-1:0] press_clr;
  logic [NUM_BTN-1:0] release_clr;
  logic [31:0]        rd_mux;
  reg_sel_e           reg_sel;
  logic               wr_irq_en;
  logic               unused_bits;

  assign reg_sel     = reg_sel_e'(address[3:2]);
  assign unused_bits = ^{address[31:4], address[1:0], wdata};

  // Two-flop synchroniser for the asynchronous button levels.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_s1 <= '0;
      sync_s2 <= '0;
    end else begin
      sync_s1 <= btn_in;
      sync_s2 <= sync_s1;
    end
  end

  // Next-state debounce: a change is accepted only after DEBOUNCE_CYCLES
  // consecutive cycles of disagreement between s2 and the stable level.
  always_comb begin
    stable_nxt = stable;
    for (int unsigned i = 0; i < NUM_BTN; i++) begin
      cnt_nxt[i] = '0;
      if (sync_s2[i] != stable[i]) begin
        if (cnt[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
          stable_nxt[i] = sync_s2[i];
        end else begin
          cnt_nxt[i] = cnt[i] + 1'b1;
        end
      end
    end
  end

  // Debounce state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stable <= '0;
      for (int unsigned i = 0; i < NUM_BTN; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      stable <= stable_nxt;
      for (int unsigned i = 0; i < NUM_BTN; i++) begin
        cnt[i] <= cnt_nxt[i];
      end
    end
  end

  // Edge detection on the stable level and read-to-clear decode.
  always_comb begin
    press_set   = stable_nxt & ~stable;
    release_set = stable & ~stable_nxt;
    press_clr   = (ren && reg_sel == REG_PRESS)   ? '1 : '0;
    release_clr = (ren && reg_sel == REG_RELEASE) ? '1 : '0;
    wr_irq_en   = wen && !ren && reg_sel == REG_IRQ_EN;
  end

  // Read data mux; bits above NUM_BTN read as zero.
  always_comb begin
    rd_mux = '0;
    case (reg_sel)
      REG_STATE:   rd_mux[NUM_BTN-1:0] = stable;
      REG_PRESS:   rd_mux[NUM_BTN-1:0] = press_q;
      REG_RELEASE: rd_mux[NUM_BTN-1:0] = release_q;
      REG_IRQ_EN:  rd_mux[NUM_BTN-1:0] = irq_en_q;
      default:     rd_mux = '0;
    endcase
  end

  // Sticky flags (set wins over clear per bit), IRQ enable and read response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      press_q   <= '0;
      release_q <= '0;
      irq_en_q  <= '0;
      data_out  <= '0;
      rvalid    <= 1'b0;
    end else begin
      press_q   <= (press_q & ~press_clr) | press_set;
      release_q <= (release_q & ~release_clr) | release_set;
      if (wr_irq_en) begin
        irq_en_q <= wdata[NUM_BTN-1:0];
      end
      rvalid <= ren;
      if (ren) begin
        data_out <= rd_mux;
      end
    end
  end

  // Registered level interrupt from the currently held flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq <= 1'b0;
    end else begin
      irq <= |((press_q | release_q) & irq_en_q);
    end
  end

endmodule

// File: tb/tb_button_bank.sv
// tb_button_bank: directed test of button_bank with DEBOUNCE_CYCLES=4, NUM_BTN=8.
// Inputs change 1 ns after a rising edge; outputs are sampled at that same point.
module tb_button_bank;

  localparam int unsigned NB = 8;

  logic          clk;
  logic          rst_n;
  logic [NB-1:0] btn_in;
  logic          ren;
  logic          wen;
  logic [31:0]   address;
  logic [31:0]   wdata;
  logic [31:0]   data_out;
  logic          rvalid;
  logic          irq;

  int unsigned n_checks;
  int unsigned n_errors;

  localparam logic [1:0] A_STATE   = 2'b00;
  localparam logic [1:0] A_PRESS   = 2'b01;
  localparam logic [1:0] A_RELEASE = 2'b10;
  localparam logic [1:0] A_IRQ_EN  = 2'b11;

  button_bank #(
    .NUM_BTN        (NB),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn_in  (btn_in),
    .ren     (ren),
    .wen     (wen),
    .address (address),
    .wdata   (wdata),
    .data_out(data_out),
    .rvalid  (rvalid),
    .irq     (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    address = {28'd0, a, 2'b00};
    ren     = 1'b1;
    tick(1);
    ren     = 1'b0;
    check("rvalid_on_read", {31'd0, rvalid}, 32'd1);
    d = data_out;
  endtask

  task automatic read_check(input string tag, input logic [1:0] a, input logic [31:0] exp);
    logic [31:0] d;
    bus_read(a, d);
    check(tag, d, exp);
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    address = {28'd0, a, 2'b00};
    wdata   = d;
    wen     = 1'b1;
    tick(1);
    wen     = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n    = 1'b0;
    btn_in   = 8'hFF;
    ren      = 1'b0;
    wen      = 1'b0;
    address  = '0;
    wdata    = '0;

    // 1: reset with all buttons held
    tick(3);
    check("rst_data_out", data_out, 32'd0);
    check("rst_rvalid", {31'd0, rvalid}, 32'd0);
    check("rst_irq", {31'd0, irq}, 32'd0);
    rst_n = 1'b1;
    tick(5);
    read_check("rst_state_edge6", A_STATE, 32'h00);
    read_check("rst_state_edge7", A_STATE, 32'hFF);
    read_check("rst_press", A_PRESS, 32'hFF);
    read_check("rst_press_again", A_PRESS, 32'h00);
    btn_in = 8'h00;
    tick(8);
    read_check("rst_release", A_RELEASE, 32'hFF);
    read_check("rst_state_low", A_STATE, 32'h00);

    // 2: three-cycle glitch on channel 0
    bus_write(A_IRQ_EN, 32'hFFFF_FFFF);
    read_check("irq_en_readback", A_IRQ_EN, 32'hFF);
    btn_in = 8'h01;
    tick(3);
    btn_in = 8'h00;
    tick(10);
    check("glitch_irq", {31'd0, irq}, 32'd0);
    read_check("glitch_state", A_STATE, 32'h00);
    read_check("glitch_press", A_PRESS, 32'h00);
    bus_write(A_IRQ_EN, 32'h0);

    // 3: clean press on channel 3, exact latency
    btn_in = 8'h08;
    tick(5);
    read_check("ch3_state_edge6", A_STATE, 32'h00);
    read_check("ch3_state_edge7", A_STATE, 32'h08);
    read_check("ch3_press", A_PRESS, 32'h08);
    read_check("ch3_press_again", A_PRESS, 32'h00);

    // 4: IRQ on release of channel 2
    btn_in = 8'h0C;
    tick(8);
    read_check("ch2_press", A_PRESS, 32'h04);
    bus_write(A_IRQ_EN, 32'h04);
    tick(1);
    check("irq_idle", {31'd0, irq}, 32'd0);
    btn_in = 8'h08;
    tick(6);
    check("irq_same_edge_as_flag", {31'd0, irq}, 32'd0);
    tick(1);
    check("irq_one_after_flag", {31'd0, irq}, 32'd1);
    read_check("ch2_release", A_RELEASE, 32'h04);
    check("irq_still_high", {31'd0, irq}, 32'd1);
    tick(1);
    check("irq_cleared", {31'd0, irq}, 32'd0);
    read_check("irq_en_04", A_IRQ_EN, 32'h04);

    // 5: PRESS read collides with channel 5 rising
    bus_write(A_IRQ_EN, 32'h0);
    btn_in = 8'h28;
    tick(5);
    read_check("collide_press", A_PRESS, 32'h00);
    read_check("collide_press_next", A_PRESS, 32'h20);
    tick(1);
    check("rvalid_drop", {31'd0, rvalid}, 32'd0);
    check("data_out_hold", data_out, 32'h20);

    // Ignored writes: to STATE, and a write coinciding with a read
    bus_write(A_STATE, 32'hFFFF_FFFF);
    read_check("state_write_ignored", A_STATE, 32'h28);
    address = {28'd0, A_IRQ_EN, 2'b00};
    wdata   = 32'hFF;
    ren     = 1'b1;
    wen     = 1'b1;
    tick(1);
    ren     = 1'b0;
    wen     = 1'b0;
    check("ren_wen_read", data_out, 32'h00);
    read_check("ren_wen_no_write", A_IRQ_EN, 32'h00);

    // 6: async reset in the middle of a debounce count on channel 1
    read_check("pre_reset_state", A_STATE, 32'h28);
    btn_in = 8'h2A;
    tick(4);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_data_out", data_out, 32'd0);
    check("async_rst_irq", {31'd0, irq}, 32'd0);
    btn_in = 8'h02;
    tick(2);
    rst_n = 1'b1;
    tick(5);
    read_check("post_rst_state_edge6", A_STATE, 32'h00);
    read_check("post_rst_state_edge7", A_STATE, 32'h02);
    read_check("post_rst_release", A_RELEASE, 32'h00);
    read_check("post_rst_press", A_PRESS, 32'h02);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
